// File: rtl/dbus_arbiter.sv
// Two-master DBus arbiter: registered request/grant handshake, muxes the
// granted master onto the shared slave side and routes the response back.
module dbus_arbiter #(
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FIXED_PRIORITY = 0
) (
  input  logic                    i_Clk,
  input  logic                    i_nReset,
  // Master 0
  input  logic                    i_M0_Req,
  output logic                    o_M0_Gnt,
  input  logic [ADDR_WIDTH-1:0]   i_M0_Address,
  input  logic [DATA_WIDTH/8-1:0] i_M0_ByteEn,
  input  logic                    i_M0_Read,
  input  logic                    i_M0_Write,
  input  logic [DATA_WIDTH-1:0]   i_M0_WriteData,
  output logic [DATA_WIDTH-1:0]   o_M0_ReadData,
  output logic                    o_M0_WaitRequest,
  // Master 1
  input  logic                    i_M1_Req,
  output logic                    o_M1_Gnt,
  input  logic [ADDR_WIDTH-1:0]   i_M1_Address,
  input  logic [DATA_WIDTH/8-1:0] i_M1_ByteEn,
  input  logic                    i_M1_Read,
  input  logic                    i_M1_Write,
  input  logic [DATA_WIDTH-1:0]   i_M1_WriteData,
  output logic [DATA_WIDTH-1:0]   o_M1_ReadData,
  output logic                    o_M1_WaitRequest,
  // Shared slave side
  output logic [ADDR_WIDTH-1:0]   o_S_Address,
  output logic [DATA_WIDTH/8-1:0] o_S_ByteEn,
  output logic                    o_S_Read,
  output logic                    o_S_Write,
  output logic [DATA_WIDTH-1:0]   o_S_WriteData,
  input  logic [DATA_WIDTH-1:0]   i_S_ReadData,
  input  logic                    i_S_WaitRequest
);

  typedef enum logic [1:0] {StIdle, StGntM0, StGntM1} gnt_e;

  gnt_e r_Gnt, w_GntNext;
  logic r_Last, w_LastNext;

  always_ff @(posedge i_Clk) begin
    if (!i_nReset) begin
      r_Gnt  <= StIdle;
      r_Last <= 1'b1;  // master 0 wins the first tie
    end else begin
      r_Gnt  <= w_GntNext;
      r_Last <= w_LastNext;
    end
  end

  // A transfer stalled by the slave is never re-targeted.
  always_comb begin
    w_GntNext  = r_Gnt;
    w_LastNext = r_Last;
    if (!i_S_WaitRequest) begin
      if (i_M0_Req && i_M1_Req) begin
        if (FIXED_PRIORITY != 0) begin
          w_GntNext = StGntM0;
        end else begin
          w_GntNext = r_Last ? StGntM0 : StGntM1;
        end
      end else if (i_M0_Req) begin
        w_GntNext = StGntM0;
      end else if (i_M1_Req) begin
        w_GntNext = StGntM1;
      end else begin
        w_GntNext = StIdle;
      end
      if (w_GntNext == StGntM0) w_LastNext = 1'b0;
      if (w_GntNext == StGntM1) w_LastNext = 1'b1;
    end
  end

  assign o_M0_Gnt = (r_Gnt == StGntM0);
  assign o_M1_Gnt = (r_Gnt == StGntM1);

  always_comb begin
    o_S_Address      = '0;
    o_S_ByteEn       = '0;
    o_S_Read         = 1'b0;
    o_S_Write        = 1'b0;
    o_S_WriteData    = '0;
    o_M0_ReadData    = '0;
    o_M1_ReadData    = '0;
    // An ungranted master with a pending strobe stalls.
    o_M0_WaitRequest = i_M0_Read | i_M0_Write;
    o_M1_WaitRequest = i_M1_Read | i_M1_Write;
    unique case (r_Gnt)
      StGntM0: begin
        o_S_Address      = i_M0_Address;
        o_S_ByteEn       = i_M0_ByteEn;
        o_S_Read         = i_M0_Read;
        o_S_Write        = i_M0_Write;
        o_S_WriteData    = i_M0_WriteData;
        o_M0_ReadData    = i_S_ReadData;
        o_M0_WaitRequest = i_S_WaitRequest;
      end
      StGntM1: begin
        o_S_Address      = i_M1_Address;
        o_S_ByteEn       = i_M1_ByteEn;
        o_S_Read         = i_M1_Read;
        o_S_Write        = i_M1_Write;
        o_S_WriteData    = i_M1_WriteData;
        o_M1_ReadData    = i_S_ReadData;
        o_M1_WaitRequest = i_S_WaitRequest;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench for dbus_arbiter: a round-robin instance and a fixed-priority
// instance driven by the same master/slave stimulus.
module tb_dbus_arbiter;
  localparam int unsigned AW = 30;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          nReset;
  logic          m0Req, m0Rd, m0Wr, m1Req, m1Rd, m1Wr, sWait;
  logic [AW-1:0] m0Addr, m1Addr;
  logic [3:0]    m0Be, m1Be;
  logic [DW-1:0] m0Wd, m1Wd, sRdata;

  logic          gnt0, gnt1, wait0, wait1, sRd, sWr;
  logic [DW-1:0] rd0, rd1, sWd;
  logic [AW-1:0] sAddr;
  logic [3:0]    sBe;

  logic          fGnt0, fGnt1, fWait0, fWait1, fSRd, fSWr;
  logic [DW-1:0] fRd0, fRd1, fSWd;
  logic [AW-1:0] fSAddr;
  logic [3:0]    fSBe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dbus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)) dut (
    .i_Clk(clk), .i_nReset(nReset),
    .i_M0_Req(m0Req), .o_M0_Gnt(gnt0), .i_M0_Address(m0Addr), .i_M0_ByteEn(m0Be),
    .i_M0_Read(m0Rd), .i_M0_Write(m0Wr), .i_M0_WriteData(m0Wd),
    .o_M0_ReadData(rd0), .o_M0_WaitRequest(wait0),
    .i_M1_Req(m1Req), .o_M1_Gnt(gnt1), .i_M1_Address(m1Addr), .i_M1_ByteEn(m1Be),
    .i_M1_Read(m1Rd), .i_M1_Write(m1Wr), .i_M1_WriteData(m1Wd),
    .o_M1_ReadData(rd1), .o_M1_WaitRequest(wait1),
    .o_S_Address(sAddr), .o_S_ByteEn(sBe), .o_S_Read(sRd), .o_S_Write(sWr),
    .o_S_WriteData(sWd), .i_S_ReadData(sRdata), .i_S_WaitRequest(sWait)
  );

  dbus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)) dutFixed (
    .i_Clk(clk), .i_nReset(nReset),
    .i_M0_Req(m0Req), .o_M0_Gnt(fGnt0), .i_M0_Address(m0Addr), .i_M0_ByteEn(m0Be),
    .i_M0_Read(m0Rd), .i_M0_Write(m0Wr), .i_M0_WriteData(m0Wd),
    .o_M0_ReadData(fRd0), .o_M0_WaitRequest(fWait0),
    .i_M1_Req(m1Req), .o_M1_Gnt(fGnt1), .i_M1_Address(m1Addr), .i_M1_ByteEn(m1Be),
    .i_M1_Read(m1Rd), .i_M1_Write(m1Wr), .i_M1_WriteData(m1Wd),
    .o_M1_ReadData(fRd1), .o_M1_WaitRequest(fWait1),
    .o_S_Address(fSAddr), .o_S_ByteEn(fSBe), .o_S_Read(fSRd), .o_S_Write(fSWr),
    .o_S_WriteData(fSWd), .i_S_ReadData(sRdata), .i_S_WaitRequest(sWait)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; m0Req = 1'b1; m1Req = 1'b1; m0Rd = 1'b1; m1Rd = 1'b1;
    m0Wr = 1'b0; m1Wr = 1'b0; m0Be = 4'hF; m1Be = 4'hF; m0Wd = '0; m1Wd = '0;
    m0Addr = 30'h04000010; m1Addr = 30'h0C000000; sWait = 1'b0; sRdata = 32'hA5A5A5A5;
    repeat (3) tick();
    checks++; if (sRd !== 1'b0) begin errors++; $display("FAIL rst_sread got %b exp 0", sRd); end
    checks++; if (gnt0 !== 1'b0) begin errors++; $display("FAIL rst_gnt0 got %b exp 0", gnt0); end
    checks++; if (gnt1 !== 1'b0) begin errors++; $display("FAIL rst_gnt1 got %b exp 0", gnt1); end
    checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL rst_wait0 got %b exp 1", wait0); end
    checks++; if (wait1 !== 1'b1) begin errors++; $display("FAIL rst_wait1 got %b exp 1", wait1); end
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rst_rdata0 got %h exp 0", rd0); end
    checks++; if (sAddr !== 30'h0) begin errors++; $display("FAIL rst_saddr got %h exp 0", sAddr); end
    nReset = 1'b1;
    tick();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL rel_gnt0 got %b exp 1", gnt0); end
    checks++; if (sAddr !== 30'h04000010) begin
      errors++; $display("FAIL rel_saddr got %h exp 04000010", sAddr); end
    checks++; if (rd0 !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rel_rdata0 got %h exp a5a5a5a5", rd0); end
    checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL rel_rdata1 got %h exp 0", rd1); end
  endtask

  task automatic test_round_robin();
    logic expM1;
    expM1 = 1'b1;  // M0 already granted; M1 next
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (gnt1 !== expM1 || gnt0 !== !expM1) begin
        errors++; $display("FAIL rr_gnt[%0d] got %b%b exp %b%b", i, gnt1, gnt0, expM1, !expM1);
      end
      checks++; if (sAddr !== (expM1 ? 30'h0C000000 : 30'h04000010)) begin
        errors++; $display("FAIL rr_saddr[%0d] got %h", i, sAddr);
      end
      expM1 = !expM1;
    end
  endtask

  task automatic test_wait_hold();
    // Last grant was M0; let M0 alone take the bus for a read.
    m1Req = 1'b0; m0Addr = 30'h04000001;
    tick();
    checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL wh_start got %b exp 1", gnt0); end
    sWait = 1'b1; m1Req = 1'b1; sRdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
        errors++; $display("FAIL wh_gnt[%0d] got %b%b exp 01", i, gnt1, gnt0); end
      checks++; if (wait1 !== 1'b1 || wait0 !== 1'b1) begin
        errors++; $display("FAIL wh_wait[%0d] got %b%b exp 11", i, wait1, wait0); end
      checks++; if (rd0 !== 32'hDEADBEEF || rd1 !== 32'h0) begin
        errors++; $display("FAIL wh_rdata[%0d] got %h/%h exp deadbeef/0", i, rd0, rd1); end
    end
    sWait = 1'b0;
    tick();
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++; $display("FAIL wh_handover got %b%b exp 10", gnt1, gnt0); end
    checks++; if (sAddr !== 30'h0C000000 || rd0 !== 32'h0) begin
      errors++; $display("FAIL wh_route got %h/%h exp 0c000000/0", sAddr, rd0); end
  endtask

  task automatic test_fixed_priority();
    nReset = 1'b0; m0Rd = 1'b0; m1Rd = 1'b0; sWait = 1'b0;
    tick();
    nReset = 1'b1; m0Req = 1'b1; m1Req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (fGnt0 !== 1'b1 || fGnt1 !== 1'b0) begin
        errors++; $display("FAIL fp_gnt[%0d] got %b%b exp 01", i, fGnt1, fGnt0); end
    end
    m0Req = 1'b0;
    tick();
    checks++; if (fGnt1 !== 1'b1 || fGnt0 !== 1'b0) begin
      errors++; $display("FAIL fp_release got %b%b exp 10", fGnt1, fGnt0); end
  endtask

  task automatic test_back_to_back();
    m0Req = 1'b1; m1Req = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      m0Addr = AW'(i);
      tick();
      checks++; if (gnt0 !== 1'b1 || sAddr !== AW'(i)) begin
        errors++; $display("FAIL b2b[%0d] got gnt %b addr %h exp 1 %h", i, gnt0, sAddr, i); end
    end
  endtask

  task automatic test_write_isolation();
    // M0 holds the bus idle while M1 presents a write without requesting.
    m1Wr = 1'b1; m1Wd = 32'h12345678; m1Be = 4'b0011;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (sWr !== 1'b0 || wait1 !== 1'b1) begin
        errors++; $display("FAIL wi_block[%0d] got wr %b wait %b exp 0 1", i, sWr, wait1); end
    end
    m1Req = 1'b1; m0Req = 1'b0;
    tick();
    checks++; if (gnt1 !== 1'b1 || sWr !== 1'b1) begin
      errors++; $display("FAIL wi_gnt got gnt %b wr %b exp 1 1", gnt1, sWr); end
    checks++; if (sWd !== 32'h12345678 || sBe !== 4'b0011) begin
      errors++; $display("FAIL wi_data got %h be %b exp 12345678 0011", sWd, sBe); end
    m1Req = 1'b0;
    tick();
    checks++; if (sWr !== 1'b0 || sWd !== 32'h0 || sBe !== 4'b0000) begin
      errors++; $display("FAIL wi_after got wr %b %h be %b exp 0 0 0000", sWr, sWd, sBe); end
  endtask

  task automatic test_reset_mid();
    m1Req = 1'b1;
    tick();
    sWait = 1'b1;
    tick();
    checks++; if (gnt1 !== 1'b1 || sWr !== 1'b1) begin
      errors++; $display("FAIL rm_inflight got gnt %b wr %b exp 1 1", gnt1, sWr); end
    nReset = 1'b0;
    tick();
    checks++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0 || sWr !== 1'b0) begin
      errors++; $display("FAIL rm_abandon got %b%b wr %b exp 00 0", gnt1, gnt0, sWr); end
    // Both requesting after reset: M0 must win, showing the last-grant reset value.
    nReset = 1'b1; sWait = 1'b0; m0Req = 1'b1;
    tick();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++; $display("FAIL rm_last got %b%b exp 01", gnt1, gnt0); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_wait_hold();
    test_fixed_priority();
    test_back_to_back();
    test_write_isolation();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Two-master arbiter placed directly upstream of the shared DBus slave decode (ROM, RAM, UART, Counter, VideoDriver).
- Master 0 is CPU0's DBus port; master 1 is a second bus master such as a DMA or blitter.
- Grants the shared DBus to one master at a time using a registered request/grant handshake.
- Muxes that master's Avalon-style signals onto the slave side and routes ReadData/WaitRequest back.
- Replaces the single-bit grant register at SOC top level.

Parameters:
- ADDR_WIDTH, 30, word-address width of the DBus.
- DATA_WIDTH, 32, data width; ByteEn width is DATA_WIDTH/8.
- FIXED_PRIORITY, 0: 0 means round-robin between masters; 1 means master 0 always wins a tie.

Ports:
- i_Clk  in  1  system clock (w_SysClk domain).
- i_nReset  in  1  synchronous, active-low reset.
- i_M0_Req  in  1  master 0 requests the bus for its next access.
- o_M0_Gnt  out  1  master 0 owns the bus this cycle (registered).
- i_M0_Address  in  ADDR_WIDTH  master 0 word address.
- i_M0_ByteEn  in  DATA_WIDTH/8  master 0 byte enables.
- i_M0_Read  in  1  master 0 read strobe.
- i_M0_Write  in  1  master 0 write strobe.
- i_M0_WriteData  in  DATA_WIDTH  master 0 write data.
- o_M0_ReadData  out  DATA_WIDTH  read data returned to master 0.
- o_M0_WaitRequest  out  1  stall to master 0.
- i_M1_*, o_M1_*  same set as master 0 (Req, Gnt, Address, ByteEn, Read, Write, WriteData, ReadData, WaitRequest).
- o_S_Address  out  ADDR_WIDTH  shared DBus address to the slave decode.
- o_S_ByteEn  out  DATA_WIDTH/8  shared byte enables.
- o_S_Read  out  1  shared read strobe.
- o_S_Write  out  1  shared write strobe.
- o_S_WriteData  out  DATA_WIDTH  shared write data.
- i_S_ReadData  in  DATA_WIDTH  OR-combined slave read data.
- i_S_WaitRequest  in  1  OR-combined slave wait request.

Behaviour:
- State register r_Gnt with three states: IDLE, GNT_M0, GNT_M1. Also r_Last, the last master granted (0 or 1).
- o_Mx_Gnt = (r_Gnt == GNT_Mx); the grant is registered, never combinational.
- Reset (i_nReset low at a posedge): r_Gnt=IDLE and r_Last=1, so master 0 wins the first tie.
  - During and after reset: all o_S_* = 0, o_Mx_Gnt = 0, o_Mx_ReadData = 0.
  - o_Mx_WaitRequest = i_Mx_Read | i_Mx_Write (a requesting master stalls).
  - Reset overrides the hold rule: a transfer in flight is abandoned, and the slaves see Read/Write drop on the next cycle.
- Update rule at each posedge (not in reset):
  - If i_S_WaitRequest=1, r_Gnt and r_Last hold. The in-flight transfer is never re-targeted.
  - Else r_Gnt <= arbitrate(i_M0_Req, i_M1_Req), and r_Last updates whenever the new state is not IDLE.
- arbitrate:
  - Neither request: IDLE.
  - One request: that master.
  - Both requests, FIXED_PRIORITY=1: M0.
  - Both requests, FIXED_PRIORITY=0: the master that is not r_Last.
  - Back-to-back requests from the same master with no competitor keep the grant with no idle bubble.
- Slave-side mux (combinational from r_Gnt):
  - GNT_Mx drives o_S_* from master x.
  - IDLE drives all o_S_* to 0.
- Return path:
  - o_Mx_ReadData = i_S_ReadData when GNT_Mx, else 0.
  - When GNT_Mx: o_Mx_WaitRequest = i_S_WaitRequest.
  - When not granted: o_Mx_WaitRequest = i_Mx_Read | i_Mx_Write.
  - A master never sees another master's data or completion.
- Latency:
  - A request asserted in cycle N is granted in cycle N+1 if the bus is free.
  - Zero added latency on data; the path is purely muxed.
- Simultaneous events:
  - A Req edge during a slave wait is evaluated at the first posedge with i_S_WaitRequest=0.
  - A master dropping Req while granted releases the bus at the next non-waiting edge.
- Strobe hazard: a Read or Write without a grant never reaches the slaves.
- Target size: 120–200 lines of RTL.

Test Plan:
- Reset: hold i_nReset=0 for 3 cycles with both Req=1 and both Read=1 -> o_S_Read=0, both Gnt=0, both WaitRequest=1. Release -> next edge Gnt0=1, o_S_Address=M0 address.
- Round-robin: FIXED_PRIORITY=0, both Req=1 continuously, slave WaitRequest=0 -> grant sequence M0,M1,M0,M1; o_S_Address alternates 30'h04000010 / 30'h0C000000.
- Wait hold: M0 granted reading 30'h04000001; slave asserts WaitRequest for 4 cycles while M1 Req=1 -> Gnt0 stays 1 for all 4 cycles, M1 WaitRequest=1. ReadData 32'hDEADBEEF reaches only o_M0_ReadData. M1 is granted on the edge after WaitRequest drops.
- Fixed priority: FIXED_PRIORITY=1, both Req=1 for 5 cycles -> Gnt0=1 every cycle and M1 never granted. Drop M0 Req -> Gnt1=1 one cycle later.
- Write isolation: M1 writes 32'h12345678 with ByteEn=4'b0011 while M0 is granted and idle -> o_S_Write=0 until Gnt1, then o_S_WriteData=32'h12345678 and o_S_ByteEn=4'b0011 for exactly the granted cycle.
- Reset mid-transfer: assert i_nReset=0 while GNT_M1 and slave WaitRequest=1 -> next edge r_Gnt=IDLE, o_S_Write=0, r_Last=1.
